dmem_seq_ctrl: RTL
==================

// Module: dmem_seq_ctrl
// PURPOSE
//  Address sequencer for the 512x16 Q15 constant data memory (data_dmem_fp16).
//  On start, walks dmem from a base address with a programmable stride for a programmed length.
//  Streams the fetched words to the FPU operand path over a valid/ready interface.
//  Owns the dmem address bus; dmem read is combinational and sampled in the same cycle.
// PARAMETERS
//  AW     9   dmem address width; depth = 2**AW, all address arithmetic is modulo 2**AW
//  DW     16  dmem/stream data width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      launch job; sampled only in IDLE
//  abort      in   1      cancel job; highest priority after reset
//  cfg_base   in   AW     first address, latched on start
//  cfg_stride in   AW     address increment, latched on start (0 = repeat one word)
//  cfg_len    in   AW+1   beat count 0..512, latched on start
//  dmem_a     out  AW     dmem address
//  dmem_q     in   DW     dmem read data (combinational from dmem_a)
//  out_valid  out  1      stream beat valid
//  out_ready  in   1      stream beat accepted when valid&&ready
//  out_data   out  DW     beat data
//  out_idx    out  AW+1   beat index 0..len-1
//  out_last   out  1      final beat of job
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse, job completed normally
// BEHAVIOUR
//  Reset: state=IDLE; dmem_a=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
//  States: IDLE, RUN, FLUSH.
//  IDLE: start&&!abort -> latch cfg, addr<=cfg_base, remain<=cfg_len, idx<=0; cfg_len==0 -> FLUSH, else RUN.
//  RUN: dmem_a=addr. load = (remain!=0) && (!out_valid || out_ready).
//   On load: out_data<=dmem_q, out_valid<=1, out_idx<=idx, out_last<=(remain==1),
//   addr<=(addr+stride) mod 2**AW, remain--, idx++.
//   On accept without load: out_valid<=0.
//   Accept of beat with out_last=1 -> FLUSH, out_valid<=0.
//  FLUSH: done<=1 for exactly one cycle, then IDLE. len=0 job: no beats, done pulses two edges after start.
//  Latency: start sampled at edge E0; first out_valid high after E1. Throughput 1 beat/clk with out_ready held high.
//  Hold rule: while out_valid && !out_ready, out_data/out_idx/out_last are stable and addr does not advance.
//  start while busy: ignored; cfg changes mid-job have no effect.
//  abort: any state -> IDLE next edge; out_valid<=0, out_last<=0, done stays 0; abort+start same cycle -> abort wins, no job.
//  rst_n low mid-job: immediate return to reset values; no partial done.
//  dmem_a in IDLE/FLUSH: 0. Address wraps 511 -> 0 silently.
// STRUCTURE
//  Package dmem_seq_pkg: AW, DW, DMEM_DEPTH=512, state enum {IDLE, RUN, FLUSH}.
//  Single module, no sub-modules; dmem instanced by parent and wired to dmem_a/dmem_q.
// TESTING (bench instances data_dmem_fp16 as the memory)
//  1 base=0 stride=1 len=4, ready=1 -> 7FFF,0C88,1897,1446 on 4 consecutive clks, idx 0..3, last on 4th, done 1 clk later.
//  2 base=510 stride=1 len=3 -> 0336,F378,7FFF (wrap to 0), last on 3rd beat.
//  3 base=18 stride=20 len=5, ready toggling 1/0 -> five beats of 8000; data held stable while ready=0; done once.
//  4 len=0 -> no out_valid; done pulses 2 edges after start; busy high for 2 cycles.
//  5 base=6 stride=1 len=10, abort at 3rd beat -> out_valid low next clk, no done, busy=0; new start accepted after.
//  6 start asserted while busy, and rst_n pulsed mid-job -> second start ignored; reset clears all outputs asynchronously.

Source files
------------

// File: rtl/dmem_seq_pkg.sv
// Shared constants and state type for the dmem address sequencer.
package dmem_seq_pkg;

    localparam int unsigned AW         = 9;
    localparam int unsigned DW         = 16;
    localparam int unsigned DMEM_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/dmem_seq_ctrl.sv
// Walks the constant data memory from a base address with a programmable stride
// and streams the fetched words over a valid/ready interface.
module dmem_seq_ctrl
    import dmem_seq_pkg::*;
#(
    parameter int unsigned AW = dmem_seq_pkg::AW,
    parameter int unsigned DW = dmem_seq_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_stride,
    input  logic [AW:0]   cfg_len,
    output logic [AW-1:0] dmem_a,
    input  logic [DW-1:0] dmem_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_done_nxt;
    logic          w_load;
    logic          w_accept;

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_stride;
    logic [AW:0]   r_remain;
    logic [AW:0]   r_idx;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [AW:0]   r_out_idx;
    logic          r_last;
    logic          r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_accept    = r_valid && out_ready;
        w_load      = (r_state == RUN) && (r_remain != '0) && (!r_valid || out_ready);
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (start) w_state_nxt = (cfg_len == '0) ? FLUSH : RUN;
                RUN:     if (w_accept && r_last) w_state_nxt = FLUSH;
                // FLUSH spans two cycles: raise done, then leave while done is visible
                FLUSH:   if (r_done) w_state_nxt = IDLE;
                         else        w_done_nxt  = 1'b1;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_stride  <= '0;
            r_remain  <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_out_idx <= '0;
            r_last    <= 1'b0;
        end else if (abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr   <= cfg_base;
                        r_stride <= cfg_stride;
                        r_remain <= cfg_len;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    if (w_load) begin
                        r_data    <= dmem_q;
                        r_valid   <= 1'b1;
                        r_out_idx <= r_idx;
                        r_last    <= (r_remain == LEN_ONE);
                        r_addr    <= r_addr + r_stride;
                        r_remain  <= r_remain - LEN_ONE;
                        r_idx     <= r_idx + LEN_ONE;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_a    = (r_state == RUN) ? r_addr : '0;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_last;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
